// File: rtl/mma_job_scheduler.sv
// Job scheduler for a matrix-multiply array: arbitrates two requesters and sequences LOAD/STREAM/DRAIN.
// Define MMA_SCHED_FIXED_PRIO_EN for fixed priority (requester 0 wins); otherwise round-robin.
module mma_job_scheduler #(
  parameter int DRAIN_EXTRA = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_valid_i,
  output logic [1:0] req_ready_o,
  input  logic [2:0] req0_n_i,
  input  logic [2:0] req1_n_i,
  input  logic [4:0] req0_t_i,
  input  logic [4:0] req1_t_i,
  input  logic       abort_i,
  input  logic       mm_ov_i,
  input  logic       mm_val_i,
  output logic       mm_start_o,
  output logic [2:0] mm_n_o,
  output logic [4:0] mm_t_o,
  output logic       w_load_o,
  output logic [2:0] w_idx_o,
  output logic       x_en_o,
  output logic [4:0] x_idx_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       done_id_o,
  output logic       done_ov_o,
  output logic       done_err_o
);

  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [2:0] n_q;
  logic [4:0] t_q;
  logic       id_q, ov_q, err_q;
  logic [1:0] grant;
  logic       hs, win_id, win_ok, abort_act;
  logic [2:0] win_n;
  logic [4:0] win_t;
  logic [7:0] t_last, drain_last;

`ifdef MMA_SCHED_FIXED_PRIO_EN
  always_comb begin
    grant = 2'b00;
    if (state == IDLE) begin
      if (req_valid_i[0])      grant = 2'b01;
      else if (req_valid_i[1]) grant = 2'b10;
    end
  end
`else
  // prio_q set means requester 1 wins the next contention
  logic prio_q;

  always_comb begin
    grant = 2'b00;
    if (state == IDLE) begin
      if (req_valid_i == 2'b11) grant = prio_q ? 2'b10 : 2'b01;
      else                      grant = req_valid_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  prio_q <= 1'b0;
    else if (hs)   prio_q <= ~win_id;
  end
`endif

  assign hs          = |grant;
  assign win_id      = grant[1];
  assign win_n       = win_id ? req1_n_i : req0_n_i;
  assign win_t       = win_id ? req1_t_i : req0_t_i;
  assign win_ok      = (win_n != 3'd0) && (win_n <= 3'd5) && (win_t != 5'd0);
  assign abort_act   = abort_i && (state inside {LOAD, STREAM, DRAIN});
  assign t_last      = 8'(t_q) - 8'd1;
  assign drain_last  = 8'(n_q) + 8'(DRAIN_EXTRA) - 8'd1;
  // ready is forced low while reset is held so every output reads 0
  assign req_ready_o = grant & {2{reset_n}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 8'd1;
    case (state)
      IDLE: begin
        cnt_nxt = 8'd0;
        if (hs) state_nxt = win_ok ? LOAD : DONE;
      end
      LOAD: if (cnt == 8'd4) begin
        state_nxt = STREAM;
        cnt_nxt   = 8'd0;
      end
      STREAM: if (cnt == t_last) begin
        state_nxt = DRAIN;
        cnt_nxt   = 8'd0;
      end
      DRAIN: if (cnt == drain_last) begin
        state_nxt = DONE;
        cnt_nxt   = 8'd0;
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
    if (abort_act) begin
      state_nxt = DONE;
      cnt_nxt   = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_q   <= 3'd0;
      t_q   <= 5'd0;
      id_q  <= 1'b0;
      ov_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (hs) begin
      n_q   <= win_n;
      t_q   <= win_t;
      id_q  <= win_id;
      ov_q  <= 1'b0;
      err_q <= ~win_ok;
    end else begin
      if (abort_act) err_q <= 1'b1;
      if ((state inside {STREAM, DRAIN}) && mm_ov_i && mm_val_i) ov_q <= 1'b1;
    end
  end

  always_comb begin
    busy_o     = (state != IDLE);
    mm_start_o = (state == LOAD) && (cnt == 8'd0);
    mm_n_o     = busy_o ? n_q : 3'd0;
    mm_t_o     = busy_o ? t_q : 5'd0;
    w_load_o   = (state == LOAD);
    w_idx_o    = w_load_o ? cnt[2:0] : 3'd0;
    x_en_o     = (state == STREAM);
    x_idx_o    = x_en_o ? cnt[4:0] : 5'd0;
    done_o     = (state == DONE);
    done_id_o  = done_o & id_q;
    done_ov_o  = done_o & ov_q;
    done_err_o = done_o & err_q;
  end

endmodule

// File: tb/tb_mma_job_scheduler.sv
// Bench for mma_job_scheduler: directed scenarios plus random traffic against a job-timeline model.
module tb_mma_job_scheduler;
  localparam int DE = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] req_valid_i, req_ready_o;
  logic [2:0] req0_n_i, req1_n_i, mm_n_o, w_idx_o;
  logic [4:0] req0_t_i, req1_t_i, mm_t_o, x_idx_o;
  logic       abort_i, mm_ov_i, mm_val_i;
  logic       mm_start_o, w_load_o, x_en_o, busy_o, done_o, done_id_o, done_ov_o, done_err_o;

  mma_job_scheduler #(.DRAIN_EXTRA(DE)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req0_n_i(req0_n_i), .req1_n_i(req1_n_i), .req0_t_i(req0_t_i), .req1_t_i(req1_t_i),
    .abort_i(abort_i), .mm_ov_i(mm_ov_i), .mm_val_i(mm_val_i),
    .mm_start_o(mm_start_o), .mm_n_o(mm_n_o), .mm_t_o(mm_t_o),
    .w_load_o(w_load_o), .w_idx_o(w_idx_o), .x_en_o(x_en_o), .x_idx_o(x_idx_o),
    .busy_o(busy_o), .done_o(done_o), .done_id_o(done_id_o), .done_ov_o(done_ov_o),
    .done_err_o(done_err_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a job is a timeline measured from its handshake cycle
  bit m_active, m_id, m_err, m_ov, m_prio;
  int m_hs, m_done_e, m_n, m_t;
  int cyc = 0;

  // Observations taken from the DUT
  int dut_hs_cyc, dut_done_cyc;
  bit dut_done_ov, dut_done_err, tick_done;
  bit grants[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0 idle, 1 load, 2 stream, 3 drain, 4 done
  function automatic int phase();
    int e;
    if (!m_active) return 0;
    e = cyc - m_hs;
    if (e == m_done_e) return 4;
    if (e <= 5) return 1;
    if (e <= 5 + m_t) return 2;
    return 3;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(req_ready_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_outs"}, {mm_start_o, mm_n_o, mm_t_o, w_load_o, w_idx_o, x_en_o, x_idx_o}, 0);
    chk({tag, "_done"}, {done_o, done_id_o, done_ov_o, done_err_o}, 0);
  endtask

  task automatic drive(input logic [1:0] v, input int n0, input int t0, input int n1, input int t1);
    req_valid_i = v;
    req0_n_i = 3'(n0); req0_t_i = 5'(t0);
    req1_n_i = 3'(n1); req1_t_i = 5'(t1);
  endtask

  task automatic tick();
    int p, e, n, t;
    logic [1:0] g;
    bit win, ok;
    @(negedge clk);
    p = phase();
    e = cyc - m_hs;
    g = 2'b00;
    if (p == 0) begin
`ifdef MMA_SCHED_FIXED_PRIO_EN
      if (req_valid_i[0]) g = 2'b01;
      else if (req_valid_i[1]) g = 2'b10;
`else
      if (req_valid_i == 2'b11) g = m_prio ? 2'b10 : 2'b01;
      else g = req_valid_i;
`endif
    end
    chk("ready", 32'(req_ready_o), 32'(g));
    chk("busy", 32'(busy_o), 32'(p != 0));
    chk("mm_start", 32'(mm_start_o), 32'(p == 1 && e == 1));
    chk("mm_n", 32'(mm_n_o), (p != 0) ? 32'(m_n) : 0);
    chk("mm_t", 32'(mm_t_o), (p != 0) ? 32'(m_t) : 0);
    chk("w_load", 32'(w_load_o), 32'(p == 1));
    chk("w_idx", 32'(w_idx_o), (p == 1) ? 32'(e - 1) : 0);
    chk("x_en", 32'(x_en_o), 32'(p == 2));
    chk("x_idx", 32'(x_idx_o), (p == 2) ? 32'(e - 6) : 0);
    chk("done", 32'(done_o), 32'(p == 4));
    chk("done_id", 32'(done_id_o), 32'(p == 4 && m_id));
    chk("done_ov", 32'(done_ov_o), 32'(p == 4 && m_ov));
    chk("done_err", 32'(done_err_o), 32'(p == 4 && m_err));
    tick_done = done_o;
    if (done_o) begin
      dut_done_cyc = cyc; dut_done_ov = done_ov_o; dut_done_err = done_err_o;
    end
    if (|(req_ready_o & req_valid_i)) begin
      dut_hs_cyc = cyc;
      grants.push_back(req_ready_o[1]);
    end
    if (p == 0 && g != 2'b00) begin
      win = g[1];
      n = win ? int'(req1_n_i) : int'(req0_n_i);
      t = win ? int'(req1_t_i) : int'(req0_t_i);
      ok = (n >= 1 && n <= 5 && t >= 1);
      m_active = 1; m_hs = cyc; m_id = win; m_n = n; m_t = t;
      m_err = !ok; m_ov = 0; m_prio = !win;
      m_done_e = ok ? (5 + t + n + DE + 1) : 1;
    end else if (p == 4) begin
      m_active = 0;
    end else if (p != 0) begin
      if ((p == 2 || p == 3) && mm_ov_i && mm_val_i) m_ov = 1;
      if (abort_i) begin
        m_err = 1;
        m_done_e = e + 1;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic run_done(input string tag, input int limit);
    bit found = 0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (tick_done) begin
        found = 1;
        break;
      end
    end
    if (!found) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    reset_n = 1'b0;
    abort_i = 0; mm_ov_i = 0; mm_val_i = 0;
    drive(2'b11, 5, 4, 5, 4);
    m_active = 0; m_prio = 0; m_hs = 0; m_done_e = 0; m_n = 0; m_t = 0;
    m_id = 0; m_err = 0; m_ov = 0;
    #2;
    chk_all_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    drive(2'b00, 0, 0, 0, 0);
    ticks(2);

    // Nominal job from requester 0: N=5, T=4
    drive(2'b01, 5, 4, 0, 0);
    tick();
    drive(2'b00, 0, 0, 0, 0);
    run_done("j030", 40);
    chk("lat030", 32'(dut_done_cyc - dut_hs_cyc), 19);
    chk("j030_flags", {31'd0, dut_done_err}, 0);

    // Invalid jobs from requester 1: N=0 then N=6
    drive(2'b10, 0, 0, 0, 3);
    tick();
    drive(2'b00, 0, 0, 0, 0);
    run_done("j032a", 5);
    chk("lat032a", 32'(dut_done_cyc - dut_hs_cyc), 1);
    chk("err032a", {31'd0, dut_done_err}, 1);
    drive(2'b10, 0, 0, 6, 3);
    tick();
    drive(2'b00, 0, 0, 0, 0);
    run_done("j032b", 5);
    chk("lat032b", 32'(dut_done_cyc - dut_hs_cyc), 1);
    ticks(1);

    // Contention with both valid: grant order
    grants.delete();
    drive(2'b11, 1, 1, 1, 1);
    for (int j = 0; j < 4; j++) run_done("j031", 30);
    drive(2'b00, 0, 0, 0, 0);
    ticks(1);
    if (grants.size() != 4) chk("grant_cnt", 32'(grants.size()), 4);
    else begin
`ifdef MMA_SCHED_FIXED_PRIO_EN
      chk("grant_seq", {28'd0, grants[0], grants[1], grants[2], grants[3]}, 4'b0000);
`else
      chk("grant_seq", {28'd0, grants[0], grants[1], grants[2], grants[3]}, 4'b0101);
`endif
    end

    // Overflow during one DRAIN cycle (DRAIN begins 14 cycles after handshake)
    drive(2'b01, 3, 8, 0, 0);
    tick();
    drive(2'b00, 0, 0, 0, 0);
    ticks(13);
    mm_ov_i = 1; mm_val_i = 1;
    tick();
    mm_ov_i = 0; mm_val_i = 0;
    run_done("j033a", 30);
    chk("ov033a", {31'd0, dut_done_ov}, 1);
    drive(2'b01, 3, 8, 0, 0);
    tick();
    drive(2'b00, 0, 0, 0, 0);
    run_done("j033b", 40);
    chk("ov033b", {31'd0, dut_done_ov}, 0);

    // Abort in third STREAM cycle, then abort while idle
    drive(2'b01, 2, 6, 0, 0);
    tick();
    drive(2'b00, 0, 0, 0, 0);
    ticks(7);
    abort_i = 1;
    tick();
    abort_i = 0;
    run_done("j034", 3);
    chk("lat034", 32'(dut_done_cyc - dut_hs_cyc), 9);
    chk("err034", {31'd0, dut_done_err}, 1);
    abort_i = 1;
    ticks(3);
    abort_i = 0;

    // Reset during DRAIN, then contention after release
    drive(2'b01, 5, 2, 0, 0);
    tick();
    drive(2'b11, 2, 2, 2, 2);
    ticks(9);
    reset_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    m_active = 0; m_prio = 0;
    @(posedge clk); @(posedge clk); #1;
    chk_all_zero("rst_hold");
    reset_n = 1'b1;
    grants.delete();
    tick();
    chk("rst_grant", 32'(grants.size()), 1);
    if (grants.size() == 1) chk("rst_grant_id", {31'd0, grants[0]}, 0);
    drive(2'b00, 0, 0, 0, 0);
    run_done("j035", 30);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      drive(2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 10),
            $urandom_range(0, 7), $urandom_range(0, 10));
      abort_i  = ($urandom_range(0, 49) == 0);
      mm_ov_i  = ($urandom_range(0, 7) == 0);
      mm_val_i = $urandom_range(0, 1) == 1;
      tick();
    end
    drive(2'b00, 0, 0, 0, 0);
    abort_i = 0; mm_ov_i = 0; mm_val_i = 0;
    ticks(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
